// File: rtl/jk_walk_pkg.sv
// Shared types and J/K excitation codes for the JK Gray-style walker and its cells.
// Excitation codes are packed {J,K}.
package jk_walk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } walk_state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-low clear.
module jk_cell
    import jk_walk_pkg::*;
(
    input  logic clk,
    input  logic clear_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: r_q <= r_q;
                JK_SET:  r_q <= 1'b1;
                JK_RST:  r_q <= 1'b0;
                JK_TGL:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_gray_walker.sv
// Walks a bank of JK cells to a target one bit per clock, lowest differing bit first.
// Define JK_WALK_TOGGLE_EN to drive the changing bit with J=K=1 instead of set/reset codes.
module jk_gray_walker
    import jk_walk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    walk_state_t      r_state;
    logic [WIDTH-1:0] r_tgt;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_walk_active;

    // Abort suppresses excitation in the same cycle so no flip lands on the way out.
    assign w_diff        = w_q ^ r_tgt;
    assign w_walk_active = (r_state == WALK) && !abort;
    assign w_sel         = w_walk_active ? (w_diff & (~w_diff + W_ONE)) : '0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
`ifdef JK_WALK_TOGGLE_EN
            assign {w_j[gi], w_k[gi]} = w_sel[gi] ? JK_TGL : JK_HOLD;
`else
            assign {w_j[gi], w_k[gi]} = !w_sel[gi] ? JK_HOLD :
                                        (r_tgt[gi] ? JK_SET : JK_RST);
`endif
            jk_cell u_cell (
                .clk     (clk),
                .clear_n (clear_n),
                .j       (w_j[gi]),
                .k       (w_k[gi]),
                .q       (w_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_tgt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tgt_valid) begin
                        r_tgt   <= tgt_data;
                        r_state <= WALK;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                WALK: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else if (w_diff == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign q         = w_q;
    assign j_out     = w_j;
    assign k_out     = w_k;
    assign busy      = r_busy;
    assign done      = r_done;
    assign tgt_ready = r_ready;

endmodule

// File: tb/tb_jk_gray_walker.sv
// Directed bench for jk_gray_walker; expected J/K follow JK_WALK_TOGGLE_EN when defined.
module tb_jk_gray_walker;

`ifdef JK_WALK_TOGGLE_EN
    localparam bit TGL = 1'b1;
`else
    localparam bit TGL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready;
    logic [3:0] tgt_data = 4'b0000;
    logic       abort = 1'b0;
    logic [3:0] q;
    logic [3:0] j_out;
    logic [3:0] k_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    jk_gray_walker #(.WIDTH(4)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .abort     (abort),
        .q         (q),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected excitation for the changing bit: sel mask, and whether it goes 0->1.
    task automatic chk_jk(input string tag, input logic [3:0] sel, input bit rising);
        chk({tag, "_j"}, j_out, TGL ? sel : (rising ? sel : 4'b0000));
        chk({tag, "_k"}, k_out, TGL ? sel : (rising ? 4'b0000 : sel));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        $display("tb_jk_gray_walker start (toggle mode=%0d)", TGL);
        // Reset
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        chk("rst_q", q, 4'b0000);
        step();
        clear_n = 1'b1;
        step();
        chk("rst_q2", q, 4'b0000);
        chk("rst_ready", tgt_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_j", j_out, 4'b0000);
        chk("rst_k", k_out, 4'b0000);

        // 0000 -> 0101
        $display("txn: walk 0000 -> 0101");
        tgt_valid = 1'b1; tgt_data = 4'b0101;
        step();
        tgt_valid = 1'b0;
        chk("w1_busy", busy, 1'b1);
        chk("w1_ready", tgt_ready, 1'b0);
        chk("w1_q0", q, 4'b0000);
        chk_jk("w1_c1", 4'b0001, 1'b1);
        step();
        chk("w1_q1", q, 4'b0001);
        chk_jk("w1_c2", 4'b0100, 1'b1);
        step();
        chk("w1_q2", q, 4'b0101);
        chk_jk("w1_c3", 4'b0000, 1'b1);
        chk("w1_nodone", done, 1'b0);
        step();
        chk("w1_done", done, 1'b1);
        chk("w1_ready_d", tgt_ready, 1'b0);
        step();
        chk("w1_done_off", done, 1'b0);
        chk("w1_ready_back", tgt_ready, 1'b1);
        chk("w1_busy_off", busy, 1'b0);

        // 0101 -> 0101: zero flips
        $display("txn: walk 0101 -> 0101");
        tgt_valid = 1'b1; tgt_data = 4'b0101;
        step();
        tgt_valid = 1'b0;
        chk("w2_busy", busy, 1'b1);
        chk("w2_done0", done, 1'b0);
        chk_jk("w2_c1", 4'b0000, 1'b1);
        step();
        chk("w2_done", done, 1'b1);
        chk("w2_q", q, 4'b0101);
        step();
        chk("w2_ready", tgt_ready, 1'b1);

        // 0101 -> 1010
        $display("txn: walk 0101 -> 1010");
        tgt_valid = 1'b1; tgt_data = 4'b1010;
        step();
        tgt_valid = 1'b0;
        chk_jk("w3_c1", 4'b0001, 1'b0);
        step();
        chk("w3_q1", q, 4'b0100);
        chk_jk("w3_c2", 4'b0010, 1'b1);
        step();
        chk("w3_q2", q, 4'b0110);
        chk_jk("w3_c3", 4'b0100, 1'b0);
        step();
        chk("w3_q3", q, 4'b0010);
        chk_jk("w3_c4", 4'b1000, 1'b1);
        step();
        chk("w3_q4", q, 4'b1010);
        chk("w3_nodone", done, 1'b0);
        step();
        chk("w3_done", done, 1'b1);
        step();
        chk("w3_done_off", done, 1'b0);

        // Clear mid-walk with tgt_valid held high
        $display("txn: walk 1010 -> 0101 cleared mid-walk");
        tgt_valid = 1'b1; tgt_data = 4'b0101;
        step();
        tgt_data = 4'b1111;
        chk("c_ready", tgt_ready, 1'b0);
        step();
        chk("c_q1", q, 4'b1011);
        chk_jk("c_c2", 4'b0010, 1'b0);
        #2 clear_n = 1'b0;
        #1;
        chk("c_q_clr", q, 4'b0000);
        chk("c_busy_clr", busy, 1'b0);
        chk("c_ready_clr", tgt_ready, 1'b1);
        chk("c_j_clr", j_out, 4'b0000);
        #1 clear_n = 1'b1;

        // tgt_valid still high: accepted now, walk 0000 -> 1111, abort after q=0011
        $display("txn: walk 0000 -> 1111 abort at q=0011");
        step();
        tgt_valid = 1'b0;
        chk("a1_busy", busy, 1'b1);
        chk("a1_q0", q, 4'b0000);
        chk_jk("a1_c1", 4'b0001, 1'b1);
        step();
        chk("a1_q1", q, 4'b0001);
        step();
        chk("a1_q2", q, 4'b0011);
        abort = 1'b1;
        #1;
        chk("a1_j_abort", j_out, 4'b0000);
        chk("a1_k_abort", k_out, 4'b0000);
        step();
        abort = 1'b0;
        chk("a1_q_hold", q, 4'b0011);
        chk("a1_idle_ready", tgt_ready, 1'b1);
        chk("a1_busy_off", busy, 1'b0);
        chk("a1_nodone", done, 1'b0);
        step();
        chk("a1_nodone2", done, 1'b0);
        chk("a1_q_hold2", q, 4'b0011);

        // Abort coinciding with last pending flip
        $display("txn: walk 0000 -> 1111 abort on last flip");
        clear_n = 1'b0;
        #1 clear_n = 1'b1;
        tgt_valid = 1'b1; tgt_data = 4'b1111;
        step();
        tgt_valid = 1'b0;
        step();
        step();
        step();
        chk("a2_q3", q, 4'b0111);
        chk_jk("a2_c4", 4'b1000, 1'b1);
        abort = 1'b1;
        #1;
        chk("a2_j_abort", j_out, 4'b0000);
        step();
        abort = 1'b0;
        chk("a2_q_hold", q, 4'b0111);
        chk("a2_ready", tgt_ready, 1'b1);
        chk("a2_nodone", done, 1'b0);
        step();
        chk("a2_nodone2", done, 1'b0);
        chk("a2_q_hold2", q, 4'b0111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
